// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command decoder: ASCII codes of the
// recognised command characters, the decoder state encoding, time-field
// limits and a small digit classification helper.
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

  // Command and separator characters (upper/lower case accepted for letters)
  localparam logic [7:0] CHAR_R_UP  = 8'h52;
  localparam logic [7:0] CHAR_R_LO  = 8'h72;
  localparam logic [7:0] CHAR_C_UP  = 8'h43;
  localparam logic [7:0] CHAR_C_LO  = 8'h63;
  localparam logic [7:0] CHAR_M_UP  = 8'h4D;
  localparam logic [7:0] CHAR_M_LO  = 8'h6D;
  localparam logic [7:0] CHAR_T_UP  = 8'h54;
  localparam logic [7:0] CHAR_T_LO  = 8'h74;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_0     = 8'h30;
  localparam logic [7:0] CHAR_9     = 8'h39;

  // Six digits HHMMSS are collected; index of the last one
  localparam logic [2:0] LAST_DIGIT_IDX = 3'd5;

  // Upper limits of the time fields
  localparam logic [6:0] HOUR_MAX   = 7'd23;
  localparam logic [6:0] MINSEC_MAX = 7'd59;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_WAIT_EOL = 2'd2
  } state_t;

  // True for ASCII '0'..'9'
  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CHAR_0) && (b <= CHAR_9);
  endfunction

endpackage

// File: rtl/bcd2_to_bin.sv
// -----------------------------------------------------------------------------
// bcd2_to_bin
// Converts a two-digit BCD pair to binary and compares it against a limit.
// Ports:
//   tens[3:0], ones[3:0] : BCD digits (0..9 each)
//   limit[6:0]           : largest accepted value (inclusive)
//   value[6:0]           : tens*10 + ones (max 99, fits 7 bits)
//   in_range             : value <= limit
// -----------------------------------------------------------------------------
module bcd2_to_bin (
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [6:0] limit,
  output logic [6:0] value,
  output logic       in_range
);

  assign value    = ({3'b000, tens} * 7'd10) + {3'b000, ones};
  assign in_range = (value <= limit);

endmodule

// File: rtl/uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder
// Decodes single-character button commands (R/C/M) and "THHMMSS<CR|LF>"
// set-time commands arriving byte by byte from a UART receiver.
// Ports:
//   clk             : system clock, rising edge
//   reset           : synchronous, active-low reset
//   rx_data[7:0]    : received byte, valid while rx_done=1
//   rx_done         : one-cycle byte strobe
//   btn_run_stop    : one-cycle pulse on 'R'/'r'
//   btn_clear       : one-cycle pulse on 'C'/'c'
//   btn_mode        : one-cycle pulse on 'M'/'m'
//   set_time_valid  : one-cycle pulse, set_* carry a new valid time
//   set_hour/min/sec: last committed time, held until the next commit
//   cmd_error       : one-cycle pulse on a rejected byte, command or timeout
// All pulses appear in the cycle after the rx_done cycle (or after the
// timeout terminal count) and are mutually exclusive.
// -----------------------------------------------------------------------------
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int TIMEOUT_MS = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       btn_run_stop,
  output logic       btn_clear,
  output logic       btn_mode,
  output logic       set_time_valid,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       cmd_error
);

  localparam int TIMEOUT_CYCLES = CLOCK_FREQ / 1000 * TIMEOUT_MS;
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_TC = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t             state_r;
  logic [2:0]         digit_idx_r;
  logic [3:0]         digit_r [0:5];
  logic [TIMER_W-1:0] timer_r;

  logic [6:0] hour_value_s;
  logic [6:0] min_value_s;
  logic [6:0] sec_value_s;
  logic       hour_ok_s;
  logic       min_ok_s;
  logic       sec_ok_s;
  logic       time_ok_s;

  bcd2_to_bin u_hour (
    .tens     (digit_r[0]),
    .ones     (digit_r[1]),
    .limit    (HOUR_MAX),
    .value    (hour_value_s),
    .in_range (hour_ok_s)
  );

  bcd2_to_bin u_min (
    .tens     (digit_r[2]),
    .ones     (digit_r[3]),
    .limit    (MINSEC_MAX),
    .value    (min_value_s),
    .in_range (min_ok_s)
  );

  bcd2_to_bin u_sec (
    .tens     (digit_r[4]),
    .ones     (digit_r[5]),
    .limit    (MINSEC_MAX),
    .value    (sec_value_s),
    .in_range (sec_ok_s)
  );

  // The high bits dropped by truncation to the port widths are also required
  // to be zero, so a corrupted conversion can never commit an aliased value.
  assign time_ok_s = hour_ok_s && min_ok_s && sec_ok_s &&
                     (hour_value_s[6:5] == 2'b00) &&
                     (min_value_s[6] == 1'b0) &&
                     (sec_value_s[6] == 1'b0);

  // Command FSM, digit storage, timeout counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      digit_idx_r    <= 3'd0;
      timer_r        <= '0;
      for (int i = 0; i < 6; i++) begin
        digit_r[i] <= 4'd0;
      end
      btn_run_stop   <= 1'b0;
      btn_clear      <= 1'b0;
      btn_mode       <= 1'b0;
      set_time_valid <= 1'b0;
      cmd_error      <= 1'b0;
      set_hour       <= 5'd0;
      set_min        <= 6'd0;
      set_sec        <= 6'd0;
    end else begin
      btn_run_stop   <= 1'b0;
      btn_clear      <= 1'b0;
      btn_mode       <= 1'b0;
      set_time_valid <= 1'b0;
      cmd_error      <= 1'b0;

      // A byte always wins over a coincident timeout
      if (rx_done) begin
        timer_r <= '0;
        case (state_r)
          ST_IDLE: begin
            case (rx_data)
              CHAR_R_UP, CHAR_R_LO: btn_run_stop <= 1'b1;
              CHAR_C_UP, CHAR_C_LO: btn_clear    <= 1'b1;
              CHAR_M_UP, CHAR_M_LO: btn_mode     <= 1'b1;
              CHAR_T_UP, CHAR_T_LO: begin
                digit_idx_r <= 3'd0;
                state_r     <= ST_COLLECT;
              end
              CHAR_CR, CHAR_LF, CHAR_SPACE: begin
                state_r <= ST_IDLE;
              end
              default: cmd_error <= 1'b1;
            endcase
          end

          ST_COLLECT: begin
            if (is_digit(rx_data)) begin
              // For '0'..'9' the low nibble equals byte - 0x30
              for (int i = 0; i < 6; i++) begin
                if (digit_idx_r == 3'(i)) begin
                  digit_r[i] <= rx_data[3:0];
                end
              end
              digit_idx_r <= digit_idx_r + 3'd1;
              if (digit_idx_r == LAST_DIGIT_IDX) begin
                state_r <= ST_WAIT_EOL;
              end else begin
                state_r <= ST_COLLECT;
              end
            end else begin
              cmd_error <= 1'b1;
              state_r   <= ST_IDLE;
            end
          end

          ST_WAIT_EOL: begin
            state_r <= ST_IDLE;
            if ((rx_data == CHAR_CR) || (rx_data == CHAR_LF)) begin
              if (time_ok_s) begin
                set_hour       <= hour_value_s[4:0];
                set_min        <= min_value_s[5:0];
                set_sec        <= sec_value_s[5:0];
                set_time_valid <= 1'b1;
              end else begin
                cmd_error <= 1'b1;
              end
            end else begin
              cmd_error <= 1'b1;
            end
          end

          default: state_r <= ST_IDLE;
        endcase
      end else if (state_r != ST_IDLE) begin
        if (timer_r == TIMER_TC) begin
          state_r   <= ST_IDLE;
          cmd_error <= 1'b1;
          timer_r   <= '0;
        end else begin
          timer_r <= timer_r + 1'b1;
        end
      end else begin
        timer_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_decoder
// Directed self-checking bench for uart_cmd_decoder. Timeout scaled to
// CLOCK_FREQ=20_000, TIMEOUT_MS=1 -> 20 cycles from the last byte's edge.
// -----------------------------------------------------------------------------
module tb_uart_cmd_decoder;

  localparam int TMO_CYCLES = 20;

  // Pulse vector order: {run_stop, clear, mode, time_valid, error}
  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_RUN  = 5'b10000;
  localparam logic [4:0] P_CLR  = 5'b01000;
  localparam logic [4:0] P_MODE = 5'b00100;
  localparam logic [4:0] P_SET  = 5'b00010;
  localparam logic [4:0] P_ERR  = 5'b00001;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       btn_run_stop;
  logic       btn_clear;
  logic       btn_mode;
  logic       set_time_valid;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       cmd_error;

  logic [4:0]  pulses;
  logic [16:0] time_v;

  int checks = 0;
  int errors = 0;

  assign pulses = {btn_run_stop, btn_clear, btn_mode, set_time_valid, cmd_error};
  assign time_v = {set_hour, set_min, set_sec};

  uart_cmd_decoder #(
    .CLOCK_FREQ (20_000),
    .TIMEOUT_MS (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_done        (rx_done),
    .btn_run_stop   (btn_run_stop),
    .btn_clear      (btn_clear),
    .btn_mode       (btn_mode),
    .set_time_valid (set_time_valid),
    .set_hour       (set_hour),
    .set_min        (set_min),
    .set_sec        (set_sec),
    .cmd_error      (cmd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle; returns #1 after the accepting edge.
  // rx_data is left holding 'R' afterwards, which must be ignored.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'h52;
  endtask

  // Send a byte, check its pulse in the following cycle and that it lasts one cycle
  task automatic expect_byte(input string tag, input logic [7:0] b, input logic [4:0] exp);
    send_byte(b);
    check({tag, "_pulse"}, {27'd0, pulses}, {27'd0, exp});
    @(posedge clk);
    #1;
    check({tag, "_once"}, {27'd0, pulses}, {27'd0, P_NONE});
  endtask

  // Send a string; every byte but the last must be silent
  task automatic expect_seq(input string tag, input string s, input logic [4:0] last_exp);
    for (int i = 0; i < s.len(); i++) begin
      expect_byte($sformatf("%s_%0d", tag, i), s[i],
                  (i == s.len() - 1) ? last_exp : P_NONE);
    end
  endtask

  initial begin
    int cnt;
    int seen;
    reset   = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_pulses", {27'd0, pulses}, 32'd0);
    check("rst_time", {15'd0, time_v}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 'r': pulse only in the cycle after rx_done, nothing else moves
    @(negedge clk);
    check("r_pre", {27'd0, pulses}, {27'd0, P_NONE});
    expect_byte("r", 8'h72, P_RUN);
    check("r_time", {15'd0, time_v}, 32'd0);

    // Other buttons, ignored bytes, unknown byte
    expect_byte("R", 8'h52, P_RUN);
    expect_byte("c", 8'h63, P_CLR);
    expect_byte("C", 8'h43, P_CLR);
    expect_byte("m", 8'h6D, P_MODE);
    expect_byte("M", 8'h4D, P_MODE);
    expect_byte("sp", 8'h20, P_NONE);
    expect_byte("cr", 8'h0D, P_NONE);
    expect_byte("lf", 8'h0A, P_NONE);
    expect_byte("x", 8'h78, P_ERR);

    // Valid maximum time
    expect_seq("t235959", "T235959\r", P_SET);
    check("t235959_time", {15'd0, time_v}, {15'd0, 5'd23, 6'd59, 6'd59});

    // Out-of-range commands leave the time unchanged
    expect_seq("t240000", "T240000\n", P_ERR);
    check("t240000_time", {15'd0, time_v}, {15'd0, 5'd23, 6'd59, 6'd59});
    expect_seq("t235960", "T235960\r", P_ERR);
    expect_seq("t236000", "T236000\r", P_ERR);
    check("t236000_time", {15'd0, time_v}, {15'd0, 5'd23, 6'd59, 6'd59});

    // Minimum time, lower-case t
    expect_seq("t000000", "t000000\n", P_SET);
    check("t000000_time", {15'd0, time_v}, 32'd0);

    // Seventh digit where a terminator is expected
    expect_seq("t7dig", "T1234567", P_ERR);
    expect_byte("t7dig_cr", 8'h0D, P_NONE);

    // Non-digit in COLLECT, then back in IDLE
    expect_seq("t12a", "T12a", P_ERR);
    expect_byte("t12a_C", 8'h43, P_CLR);

    // Timeout after partial command
    expect_byte("tmo_T", 8'h54, P_NONE);
    expect_byte("tmo_1", 8'h31, P_NONE);
    send_byte(8'h32);
    check("tmo_2", {27'd0, pulses}, {27'd0, P_NONE});
    cnt  = 0;
    seen = 0;
    while (seen == 0 && cnt < 3 * TMO_CYCLES) begin
      @(posedge clk);
      #1;
      cnt++;
      if (pulses != P_NONE) seen = 1;
    end
    check("tmo_cycles", cnt, TMO_CYCLES);
    check("tmo_pulse", {27'd0, pulses}, {27'd0, P_ERR});
    @(posedge clk);
    #1;
    check("tmo_once", {27'd0, pulses}, {27'd0, P_NONE});
    expect_byte("tmo_M", 8'h4D, P_MODE);

    // Byte arriving exactly at the terminal count wins over the timeout
    expect_byte("co_T", 8'h54, P_NONE);
    send_byte(8'h31);
    seen = 0;
    repeat (TMO_CYCLES - 1) begin
      @(posedge clk);
      #1;
      if (pulses != P_NONE) seen = 1;
    end
    check("co_quiet", seen, 0);
    expect_byte("co_2", 8'h32, P_NONE);
    expect_seq("co_rest", "3456\r", P_SET);
    check("co_time", {15'd0, time_v}, {15'd0, 5'd12, 6'd34, 6'd56});

    // Reset mid-command abandons it silently
    expect_seq("rm", "T1234", P_NONE);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rm_pulses", {27'd0, pulses}, {27'd0, P_NONE});
    check("rm_time", {15'd0, time_v}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    expect_byte("rm_5", 8'h35, P_ERR);
    expect_byte("rm_6", 8'h36, P_ERR);
    expect_byte("rm_cr", 8'h0D, P_NONE);
    check("rm_time_after", {15'd0, time_v}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
